wb_trace_checker: RTL
=====================

// Module: wb_trace_checker
// PURPOSE
//  Consumes the CPU's write-back debug trace (debug_wb_* outputs of the pipelined miniRV top) and
//  checks every retired instruction against a golden trace held in an external synchronous ROM.
//  Sits beside the CPU top in the simulation/FPGA harness and reports PASS/FAIL, retired count and
//  the first mismatch.
//  The trace ROM is prefetched into a 2-entry buffer so that one retirement per clock is checked
//  with no stall.
// PARAMETERS
//  ADDR_W   16     golden trace ROM address width (entries)
//  TIMEOUT  4096   max consecutive cycles in RUN without a retirement before FAIL
// PORTS
//  clk_i           in   1    clock
//  rst_i           in   1    reset, asynchronous, active-high
//  wb_have_inst_i  in   1    WB stage holds a retiring instruction
//  wb_pc_i         in   32   WB pc
//  wb_ena_i        in   1    WB regfile write enable
//  wb_reg_i        in   5    WB destination register
//  wb_value_i      in   32   WB write data
//  trace_addr_o    out  ADDR_W  golden ROM read address
//  trace_rd_o      out  1    golden ROM read strobe; data valid on trace_data_i the NEXT cycle
//  trace_data_i    in   71   {end[70], pc[69:38], ena[37], reg[36:32], value[31:0]}
//  done_o          out  1    check finished (PASS or FAIL), sticky
//  pass_o          out  1    finished with no error, sticky
//  err_code_o      out  3    0 none,1 pc,2 ena,3 reg,4 value,5 underrun,6 timeout,7 extra-inst
//  inst_cnt_o      out  32   instructions retired and matched
//  fail_pc_o       out  32   WB pc of the failing retirement (0 for timeout)
//  exp_value_o     out  32   golden value of the failing entry
//  got_value_o     out  32   WB value of the failing retirement
// BEHAVIOUR
//  Reset: all outputs 0, state PREFETCH, buffer empty, inflight 0, addr 0, end_seen 0.
//  States: PREFETCH -> RUN when buffer holds 2 entries or its head is an end entry;
//   RUN -> PASS/FAIL; PASS, FAIL are terminal until reset.
//  Fetch: trace_rd_o=1 when not terminal, end_seen=0, addr not exhausted, count+inflight<2.
//   Each read increments trace_addr_o; after reading address 2^ADDR_W-1 set exhausted.
//   No wrap-around. Returned data pushed next cycle; end bit set -> end_seen=1.
//  Retirement during PREFETCH: error 5 (underrun). Retirement in RUN with empty buffer: error 5.
//  Check (RUN, wb_have_inst_i=1, head valid, head.end=0), in priority order:
//   pc differs -> 1;
//   ena differs -> 2;
//   ena=1 and reg differs -> 3;
//   ena=1, reg!=0 and value differs -> 4.
//   reg/value are ignored when ena=0; value is ignored for x0.
//   Match: pop head, inst_cnt_o+1 in same edge.
//  Head is an end entry:
//   retirement that cycle -> error 7;
//   else PASS on the next edge: done_o=1, pass_o=1.
//  Any error: FAIL on the same edge; latch err_code_o, fail_pc_o, exp_value_o, got_value_o;
//   done_o=1, pass_o=0; inst_cnt_o frozen.
//  Timeout counter: counts RUN cycles with no retirement; clears on a retirement.
//   Reaching TIMEOUT -> error 6.
//  Push and pop in the same cycle: both take effect; the count is unchanged.
//  A read returning after FAIL/PASS is discarded. Async reset mid-run returns to the reset state
//   immediately.
//  Latency: result is visible one cycle after the retiring WB cycle.
// TESTING
//  1. ROM {pc0 ena1 r1 5},{pc4 ena0},{end}; CPU retires both back-to-back
//     -> inst_cnt=2, pass_o=1 one cycle after the end entry reaches the head.
//  2. Golden value 5, WB value 6, r1 -> FAIL, err=4, fail_pc=0, exp=5, got=6, inst_cnt frozen at 0.
//  3. Golden ena=1 r0 val 9, WB r0 val 0 -> match (x0 value ignored); golden ena=0,
//     WB reg/value garbage -> match.
//  4. Retire 3 instructions in 3 consecutive cycles starting the first cycle of RUN
//     -> no underrun, trace_rd_o every cycle.
//  5. TIMEOUT=16, no retirement after entering RUN -> err=6 on 16th idle cycle;
//     bubble cycles (have_inst=0) mid-run reset the count only on retirement.
//  6. Extra retirement after the end entry -> err=7.
//     Assert rst_i mid-run -> all outputs 0 asynchronously, restarts at addr 0.

Source files
------------

// File: rtl/wb_trace_checker.sv
// -----------------------------------------------------------------------------
// wb_trace_checker
//
// Compares every instruction retired by the CPU's write-back stage against a
// golden trace stored in an external synchronous ROM. The checker reports
// PASS/FAIL, the number of matched retirements and details of the first
// mismatch.
//
// The ROM is read ahead into a two-entry buffer. This lets the checker match
// one retirement per clock without stalling.
//
// Parameters
//   ADDR_W   golden trace ROM address width
//   TIMEOUT  consecutive RUN cycles without a retirement before a timeout FAIL
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   wb_have_inst_i     WB stage retires an instruction this cycle
//   wb_pc_i            WB pc
//   wb_ena_i           WB register-file write enable
//   wb_reg_i           WB destination register
//   wb_value_i         WB write data
//   trace_addr_o       golden ROM read address
//   trace_rd_o         golden ROM read strobe (data arrives the next cycle)
//   trace_data_i       {end, pc[31:0], ena, reg[4:0], value[31:0]}
//   done_o, pass_o     sticky completion / success flags
//   err_code_o         0 none, 1 pc, 2 ena, 3 reg, 4 value, 5 underrun,
//                      6 timeout, 7 extra instruction
//   inst_cnt_o         retirements matched so far
//   fail_pc_o          WB pc of the failing retirement (0 on timeout)
//   exp_value_o        golden value of the failing entry
//   got_value_o        WB value of the failing retirement
// -----------------------------------------------------------------------------
module wb_trace_checker #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_have_inst_i,
    input  logic [31:0]       wb_pc_i,
    input  logic              wb_ena_i,
    input  logic [4:0]        wb_reg_i,
    input  logic [31:0]       wb_value_i,
    output logic [ADDR_W-1:0] trace_addr_o,
    output logic              trace_rd_o,
    input  logic [70:0]       trace_data_i,
    output logic              done_o,
    output logic              pass_o,
    output logic [2:0]        err_code_o,
    output logic [31:0]       inst_cnt_o,
    output logic [31:0]       fail_pc_o,
    output logic [31:0]       exp_value_o,
    output logic [31:0]       got_value_o
);

    localparam int                TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_PC    = 3'd1;
    localparam logic [2:0] ERR_ENA   = 3'd2;
    localparam logic [2:0] ERR_REG   = 3'd3;
    localparam logic [2:0] ERR_VALUE = 3'd4;
    localparam logic [2:0] ERR_UNDER = 3'd5;
    localparam logic [2:0] ERR_TMO   = 3'd6;
    localparam logic [2:0] ERR_EXTRA = 3'd7;

    typedef enum logic [1:0] {
        S_PREFETCH = 2'd0,
        S_RUN      = 2'd1,
        S_PASS     = 2'd2,
        S_FAIL     = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Two-entry prefetch buffer. buf0_q is always the head.
    logic [70:0]       buf0_q, buf1_q;
    logic [1:0]        cnt_q;
    logic              inflight_q;
    logic              end_seen_q;
    logic              exhausted_q;
    logic [ADDR_W-1:0] addr_q;
    logic [TMO_W-1:0]  tmo_q;

    logic [31:0] inst_cnt_q;
    logic [2:0]  err_q;
    logic [31:0] fail_pc_q;
    logic [31:0] exp_q;
    logic [31:0] got_q;

    logic        head_vld;
    logic        head_end;
    logic [31:0] head_pc;
    logic        head_ena;
    logic [4:0]  head_reg;
    logic [31:0] head_val;

    logic        active;
    logic        pop;
    logic        push;
    logic        fetch;
    logic [2:0]  occ;
    logic [2:0]  err_d;

    assign head_vld = (cnt_q != 2'd0);
    assign head_end = buf0_q[70];
    assign head_pc  = buf0_q[69:38];
    assign head_ena = buf0_q[37];
    assign head_reg = buf0_q[36:32];
    assign head_val = buf0_q[31:0];

    assign active = (state_q == S_PREFETCH) || (state_q == S_RUN);

    // ---- check / next-state ----
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        err_d   = ERR_NONE;
        case (state_q)
            S_PREFETCH: begin
                if (wb_have_inst_i) begin
                    err_d = ERR_UNDER;
                end else if (cnt_q == 2'd2 || (head_vld && head_end)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wb_have_inst_i) begin
                    if (!head_vld)                                  err_d = ERR_UNDER;
                    else if (head_end)                              err_d = ERR_EXTRA;
                    else if (wb_pc_i != head_pc)                    err_d = ERR_PC;
                    else if (wb_ena_i != head_ena)                  err_d = ERR_ENA;
                    else if (head_ena && wb_reg_i != head_reg)      err_d = ERR_REG;
                    else if (head_ena && head_reg != 5'd0 &&
                             wb_value_i != head_val)                err_d = ERR_VALUE;
                    else                                            pop   = 1'b1;
                end else if (head_vld && head_end) begin
                    state_d = S_PASS;
                end else if (tmo_q == TMO_LAST) begin
                    err_d = ERR_TMO;
                end
            end
            default: ;
        endcase
        if (err_d != ERR_NONE) begin
            state_d = S_FAIL;
        end
    end

    // Occupancy counts this cycle's pop. A slot freed by the current
    // retirement can therefore be refilled at once. This keeps one retirement
    // per cycle flowing even when the buffer started full.
    assign occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fetch = active && !end_seen_q && !exhausted_q && (occ < 3'd2);
    assign push  = active && inflight_q;

    assign trace_rd_o   = fetch && !rst_i;
    assign trace_addr_o = addr_q;
    assign done_o       = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass_o       = (state_q == S_PASS);
    assign err_code_o   = err_q;
    assign inst_cnt_o   = inst_cnt_q;
    assign fail_pc_o    = fail_pc_q;
    assign exp_value_o  = exp_q;
    assign got_value_o  = got_q;

    // ---- control registers ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_PREFETCH;
            cnt_q       <= 2'd0;
            inflight_q  <= 1'b0;
            end_seen_q  <= 1'b0;
            exhausted_q <= 1'b0;
            addr_q      <= '0;
            tmo_q       <= '0;
            inst_cnt_q  <= 32'd0;
            err_q       <= ERR_NONE;
            fail_pc_q   <= 32'd0;
            exp_q       <= 32'd0;
            got_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fetch;
            cnt_q      <= cnt_q - {1'b0, pop} + {1'b0, push};
            if (push && trace_data_i[70]) begin
                end_seen_q <= 1'b1;
            end
            // The address never wraps. The last ROM word stops further reads.
            if (fetch) begin
                if (addr_q == ADDR_LAST) exhausted_q <= 1'b1;
                else                     addr_q      <= addr_q + 1'b1;
            end
            if (state_q == S_RUN && !wb_have_inst_i) tmo_q <= tmo_q + 1'b1;
            else                                     tmo_q <= '0;
            if (pop) begin
                inst_cnt_q <= inst_cnt_q + 32'd1;
            end
            if (err_d != ERR_NONE) begin
                err_q     <= err_d;
                fail_pc_q <= (err_d == ERR_TMO) ? 32'd0 : wb_pc_i;
                exp_q     <= (err_d == ERR_TMO || err_d == ERR_UNDER) ? 32'd0 : head_val;
                got_q     <= (err_d == ERR_TMO) ? 32'd0 : wb_value_i;
            end
        end
    end

    // ---- buffer data (no reset: qualified by cnt_q) ----
    always_ff @(posedge clk_i) begin
        if (pop) begin
            buf0_q <= buf1_q;
        end
        if (push) begin
            if (cnt_q == {1'b0, pop}) buf0_q <= trace_data_i;
            else                      buf1_q <= trace_data_i;
        end
    end

endmodule
